// File: rtl/register_writeback_queue_pkg.sv
// Shared types and constants for the register write-back queue.
package rf_wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] R0_INDEX = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/register_writeback_queue_fifo.sv
// Circular buffer of pending register writes: two in-order write ports, one read port,
// and a per-entry valid bit so every queued destination can be compared at once.
module wb_entry_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_a,
    input  wb_entry_t                      entry_a,
    input  logic                           push_b,
    input  wb_entry_t                      entry_b,
    input  logic                           pop,
    output wb_entry_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output wb_entry_t [DEPTH-1:0]          entries,
    output logic [DEPTH-1:0]               valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] slot_b;

    // Port A always lands first; port B follows it when both push together.
    assign slot_b = push_a ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign head   = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            // Clear before set: a push into the slot being popped (full queue) keeps it valid.
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (push_a) begin
                entries[wr_ptr] <= entry_a;
                valid[wr_ptr]   <= 1'b1;
            end
            if (push_b) begin
                entries[slot_b] <= entry_b;
                valid[slot_b]   <= 1'b1;
            end
            wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
            count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/register_writeback_queue.sv
// Write-back scheduler: merges Mem and ALU results, drops R0 writes, retires one
// write per cycle into the register-file decoder and flags pending RAW hazards.
module register_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = rf_wb_pkg::DATA_W,
    parameter int ADDR_W = rf_wb_pkg::ADDR_W
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Mem_Valid,
    input  logic [ADDR_W-1:0]            Mem_Rd,
    input  logic [DATA_W-1:0]            Mem_Data,
    output logic                         Mem_Ready,
    input  logic                         Alu_Valid,
    input  logic [ADDR_W-1:0]            Alu_Rd,
    input  logic [DATA_W-1:0]            Alu_Data,
    output logic                         Alu_Ready,
    input  logic                         Stall,
    input  logic [ADDR_W-1:0]            Query_Rs,
    output logic                         Query_Hit,
    output logic [ADDR_W-1:0]            Register_Select,
    output logic                         RF_Ld,
    output logic [DATA_W-1:0]            Write_Data,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Empty,
    output logic                         Full
);

    import rf_wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [CNT_W-1:0]      free_slots;
    logic                  mem_claim;
    logic                  mem_enq;
    logic                  alu_enq;
    logic                  pop;
    wb_entry_t             mem_entry;
    wb_entry_t             alu_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;

    assign free_slots = CNT_W'(DEPTH) - Count;
    assign Empty      = (Count == '0);
    assign Full       = (Count == CNT_W'(DEPTH));

    // Ready uses registered Count only; a pop in the same cycle earns no credit.
    always_comb begin
        Mem_Ready = 1'b0;
        Alu_Ready = 1'b0;
        mem_claim = 1'b0;
        if (!Reset) begin
            Mem_Ready = (free_slots != '0);
            mem_claim = Mem_Valid && Mem_Ready;
            Alu_Ready = mem_claim ? (free_slots >= CNT_W'(2)) : (free_slots != '0);
        end
    end

    assign mem_entry = '{rd: Mem_Rd, data: Mem_Data};
    assign alu_entry = '{rd: Alu_Rd, data: Alu_Data};
    assign mem_enq   = Mem_Valid && Mem_Ready && (Mem_Rd != R0_INDEX);
    assign alu_enq   = Alu_Valid && Alu_Ready && (Alu_Rd != R0_INDEX);
    assign pop       = !Reset && !Stall && !Empty;

    wb_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .reset   (Reset),
        .push_a  (mem_enq),
        .entry_a (mem_entry),
        .push_b  (alu_enq),
        .entry_b (alu_entry),
        .pop     (pop),
        .head    (head),
        .count   (Count),
        .entries (entries),
        .valid   (valid)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RF_Ld           <= 1'b0;
            Register_Select <= '0;
            Write_Data      <= '0;
        end else if (pop) begin
            RF_Ld           <= 1'b1;
            Register_Select <= head.rd;
            Write_Data      <= head.data;
        end else begin
            RF_Ld           <= 1'b0;
        end
    end

    always_comb begin
        Query_Hit = 1'b0;
        if (Query_Rs != R0_INDEX) begin
            if (RF_Ld && Register_Select == Query_Rs) begin
                Query_Hit = 1'b1;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid[i] && entries[i].rd == Query_Rs) begin
                    Query_Hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed bench for register_writeback_queue with hand-computed expectations.
module tb_register_writeback_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_Valid;
    logic [4:0]  Mem_Rd;
    logic [31:0] Mem_Data;
    logic        Mem_Ready;
    logic        Alu_Valid;
    logic [4:0]  Alu_Rd;
    logic [31:0] Alu_Data;
    logic        Alu_Ready;
    logic        Stall;
    logic [4:0]  Query_Rs;
    logic        Query_Hit;
    logic [4:0]  Register_Select;
    logic        RF_Ld;
    logic [31:0] Write_Data;
    logic [2:0]  Count;
    logic        Empty;
    logic        Full;

    int checks = 0;
    int errors = 0;

    register_writeback_queue #(
        .DEPTH  (4),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Mem_Valid       (Mem_Valid),
        .Mem_Rd          (Mem_Rd),
        .Mem_Data        (Mem_Data),
        .Mem_Ready       (Mem_Ready),
        .Alu_Valid       (Alu_Valid),
        .Alu_Rd          (Alu_Rd),
        .Alu_Data        (Alu_Data),
        .Alu_Ready       (Alu_Ready),
        .Stall           (Stall),
        .Query_Rs        (Query_Rs),
        .Query_Hit       (Query_Hit),
        .Register_Select (Register_Select),
        .RF_Ld           (RF_Ld),
        .Write_Data      (Write_Data),
        .Count           (Count),
        .Empty           (Empty),
        .Full            (Full)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Mem_Valid = 1'b0; Alu_Valid = 1'b0; Stall = 1'b0;
        Mem_Rd = '0; Mem_Data = '0; Alu_Rd = '0; Alu_Data = '0; Query_Rs = '0;
        tick(); tick();
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", Count); end
        checks++; if (RF_Ld !== 1'b0) begin errors++; $display("FAIL reset_rf_ld got %b want 0", RF_Ld); end
        checks++; if (Register_Select !== 5'd0 || Write_Data !== 32'd0) begin errors++;
            $display("FAIL reset_outputs got sel=%0d data=%h want 0/0", Register_Select, Write_Data); end
        checks++; if (Mem_Ready !== 1'b0 || Alu_Ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready got mem=%b alu=%b want 0/0", Mem_Ready, Alu_Ready); end
        Reset = 1'b0;
        #1;
        checks++; if (Empty !== 1'b1 || Mem_Ready !== 1'b1 || Alu_Ready !== 1'b1) begin errors++;
            $display("FAIL post_reset got empty=%b mem=%b alu=%b want 1/1/1", Empty, Mem_Ready, Alu_Ready); end
    endtask

    task automatic test_alu_single();
        Alu_Valid = 1'b1; Alu_Rd = 5'd5; Alu_Data = 32'hDEADBEEF;
        tick();
        Alu_Valid = 1'b0;
        checks++; if (Count !== 3'd1 || RF_Ld !== 1'b0) begin errors++;
            $display("FAIL single_enq got count=%0d rf_ld=%b want 1/0", Count, RF_Ld); end
        tick();
        checks++; if (RF_Ld !== 1'b1 || Register_Select !== 5'd5 || Write_Data !== 32'hDEADBEEF) begin errors++;
            $display("FAIL single_retire got ld=%b sel=%0d data=%h want 1/5/deadbeef", RF_Ld, Register_Select, Write_Data); end
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL single_count got %0d want 0", Count); end
        tick();
        checks++; if (RF_Ld !== 1'b0 || Register_Select !== 5'd5) begin errors++;
            $display("FAIL single_hold got ld=%b sel=%0d want 0/5", RF_Ld, Register_Select); end
    endtask

    task automatic test_dual();
        Mem_Valid = 1'b1; Mem_Rd = 5'd3; Mem_Data = 32'h11;
        Alu_Valid = 1'b1; Alu_Rd = 5'd4; Alu_Data = 32'h22;
        #1;
        checks++; if (Mem_Ready !== 1'b1 || Alu_Ready !== 1'b1) begin errors++;
            $display("FAIL dual_ready got mem=%b alu=%b want 1/1", Mem_Ready, Alu_Ready); end
        tick();
        Mem_Valid = 1'b0; Alu_Valid = 1'b0;
        checks++; if (Count !== 3'd2) begin errors++; $display("FAIL dual_count got %0d want 2", Count); end
        tick();
        checks++; if (RF_Ld !== 1'b1 || Register_Select !== 5'd3 || Write_Data !== 32'h11) begin errors++;
            $display("FAIL dual_first got ld=%b sel=%0d data=%h want 1/3/11", RF_Ld, Register_Select, Write_Data); end
        tick();
        checks++; if (RF_Ld !== 1'b1 || Register_Select !== 5'd4 || Write_Data !== 32'h22) begin errors++;
            $display("FAIL dual_second got ld=%b sel=%0d data=%h want 1/4/22", RF_Ld, Register_Select, Write_Data); end
        tick();
        checks++; if (RF_Ld !== 1'b0 || Empty !== 1'b1) begin errors++;
            $display("FAIL dual_done got ld=%b empty=%b want 0/1", RF_Ld, Empty); end
    endtask

    task automatic test_r0_filter();
        Alu_Valid = 1'b1; Alu_Rd = 5'd0; Alu_Data = 32'hFFFFFFFF;
        #1;
        checks++; if (Alu_Ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", Alu_Ready); end
        tick();
        Alu_Valid = 1'b0;
        checks++; if (Count !== 3'd0 || Empty !== 1'b1) begin errors++;
            $display("FAIL r0_count got count=%0d empty=%b want 0/1", Count, Empty); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (RF_Ld !== 1'b0) begin errors++; $display("FAIL r0_no_ld cycle %0d got %b want 0", i, RF_Ld); end
        end
    endtask

    task automatic test_full_stall();
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Alu_Valid = 1'b1; Alu_Rd = 5'(10 + i); Alu_Data = 32'h100 + 32'(i);
            tick();
        end
        Alu_Valid = 1'b0;
        checks++; if (Full !== 1'b1 || Count !== 3'd4 || Alu_Ready !== 1'b0 || Mem_Ready !== 1'b0) begin errors++;
            $display("FAIL full_state got full=%b count=%0d alu=%b mem=%b want 1/4/0/0", Full, Count, Alu_Ready, Mem_Ready); end
        checks++; if (RF_Ld !== 1'b0) begin errors++; $display("FAIL full_stall_ld got %b want 0", RF_Ld); end
        Stall = 1'b0; Alu_Valid = 1'b1; Alu_Rd = 5'd20;
        #1;
        checks++; if (Alu_Ready !== 1'b0 || Mem_Ready !== 1'b0) begin errors++;
            $display("FAIL full_pop_ready got alu=%b mem=%b want 0/0", Alu_Ready, Mem_Ready); end
        Alu_Valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (RF_Ld !== 1'b1 || Register_Select !== 5'(10 + i) || Write_Data !== 32'h100 + 32'(i)) begin errors++;
                $display("FAIL drain_%0d got ld=%b sel=%0d data=%h want 1/%0d/%h", i, RF_Ld, Register_Select, Write_Data, 10 + i, 32'h100 + 32'(i)); end
            tick();
        end
        checks++; if (RF_Ld !== 1'b0 || Empty !== 1'b1) begin errors++;
            $display("FAIL drain_done got ld=%b empty=%b want 0/1", RF_Ld, Empty); end
    endtask

    task automatic test_query();
        Stall = 1'b1; Alu_Valid = 1'b1; Alu_Rd = 5'd7; Alu_Data = 32'h77;
        tick();
        Alu_Valid = 1'b0;
        Query_Rs = 5'd7; #1;
        checks++; if (Query_Hit !== 1'b1) begin errors++; $display("FAIL query_hit7 got %b want 1", Query_Hit); end
        Query_Rs = 5'd8; #1;
        checks++; if (Query_Hit !== 1'b0) begin errors++; $display("FAIL query_hit8 got %b want 0", Query_Hit); end
        Query_Rs = 5'd0; #1;
        checks++; if (Query_Hit !== 1'b0) begin errors++; $display("FAIL query_hit0 got %b want 0", Query_Hit); end
        Stall = 1'b0;
        tick();
        Query_Rs = 5'd7; #1;
        checks++; if (RF_Ld !== 1'b1 || Count !== 3'd0 || Query_Hit !== 1'b1) begin errors++;
            $display("FAIL query_retiring got ld=%b count=%0d hit=%b want 1/0/1", RF_Ld, Count, Query_Hit); end
        tick();
        checks++; if (Query_Hit !== 1'b0) begin errors++; $display("FAIL query_cleared got %b want 0", Query_Hit); end
        Query_Rs = 5'd0;
    endtask

    task automatic test_stall_mid();
        Mem_Valid = 1'b1; Mem_Rd = 5'd11; Mem_Data = 32'hB;
        Alu_Valid = 1'b1; Alu_Rd = 5'd9; Alu_Data = 32'h9;
        tick();
        Mem_Valid = 1'b0; Alu_Valid = 1'b0; Stall = 1'b1;
        tick();
        checks++; if (RF_Ld !== 1'b0 || Count !== 3'd2) begin errors++;
            $display("FAIL stall_hold got ld=%b count=%0d want 0/2", RF_Ld, Count); end
        Stall = 1'b0;
        tick();
        checks++; if (RF_Ld !== 1'b1 || Register_Select !== 5'd11 || Count !== 3'd1) begin errors++;
            $display("FAIL stall_first got ld=%b sel=%0d count=%0d want 1/11/1", RF_Ld, Register_Select, Count); end
        Stall = 1'b1;
        tick();
        checks++; if (RF_Ld !== 1'b0 || Register_Select !== 5'd11 || Write_Data !== 32'hB) begin errors++;
            $display("FAIL stall_no_extend got ld=%b sel=%0d data=%h want 0/11/b", RF_Ld, Register_Select, Write_Data); end
        Stall = 1'b0;
        tick();
        checks++; if (RF_Ld !== 1'b1 || Register_Select !== 5'd9 || Write_Data !== 32'h9) begin errors++;
            $display("FAIL stall_second got ld=%b sel=%0d data=%h want 1/9/9", RF_Ld, Register_Select, Write_Data); end
        tick();
    endtask

    task automatic test_free_one();
        Stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            Alu_Valid = 1'b1; Alu_Rd = 5'(i); Alu_Data = 32'(i);
            tick();
        end
        Mem_Valid = 1'b1; Mem_Rd = 5'd13; Mem_Data = 32'hD;
        Alu_Valid = 1'b1; Alu_Rd = 5'd14; Alu_Data = 32'hE;
        #1;
        checks++; if (Mem_Ready !== 1'b1 || Alu_Ready !== 1'b0) begin errors++;
            $display("FAIL free1_ready got mem=%b alu=%b want 1/0", Mem_Ready, Alu_Ready); end
        tick();
        Mem_Valid = 1'b0;
        #1;
        checks++; if (Count !== 3'd4 || Alu_Ready !== 1'b0) begin errors++;
            $display("FAIL free1_full got count=%0d alu=%b want 4/0", Count, Alu_Ready); end
        Alu_Valid = 1'b0; Stall = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (RF_Ld !== 1'b1 || Register_Select !== ((i == 3) ? 5'd13 : 5'(i + 1))) begin errors++;
                $display("FAIL free1_order_%0d got ld=%b sel=%0d want 1/%0d", i, RF_Ld, Register_Select, (i == 3) ? 13 : i + 1); end
            tick();
        end
        checks++; if (Empty !== 1'b1 || RF_Ld !== 1'b0) begin errors++;
            $display("FAIL free1_empty got empty=%b ld=%b want 1/0 (alu rd14 must not have entered)", Empty, RF_Ld); end
    endtask

    task automatic test_reset_mid();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Alu_Valid = 1'b1; Alu_Rd = 5'(21 + i); Alu_Data = 32'hAA + 32'(i);
            tick();
        end
        Alu_Valid = 1'b0;
        checks++; if (Count !== 3'd3) begin errors++; $display("FAIL midrst_pre got %0d want 3", Count); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0; Stall = 1'b0;
        checks++; if (Count !== 3'd0 || RF_Ld !== 1'b0 || Register_Select !== 5'd0 || Empty !== 1'b1) begin errors++;
            $display("FAIL midrst_state got count=%0d ld=%b sel=%0d empty=%b want 0/0/0/1", Count, RF_Ld, Register_Select, Empty); end
        Query_Rs = 5'd22; #1;
        checks++; if (Query_Hit !== 1'b0) begin errors++; $display("FAIL midrst_query got %b want 0", Query_Hit); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (RF_Ld !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d got %b want 0", i, RF_Ld); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_dual();
        test_r0_filter();
        test_full_stall();
        test_query();
        test_stall_mid();
        test_free_one();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
